// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the hazard/stall logic.
// Holds the default register-address width, the pending-slot layout and the zero-register constant.
package pipeline_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

    // Packed layout of one pending-load slot: valid bit above the register address.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
    } pend_slot_t;

endpackage

// File: rtl/load_pending_pipe.sv
// Shift register of loads that have left EX but are not yet forwardable.
// Slot 0 is the load that left EX one cycle ago; the last slot drops out on each shift.
module load_pending_pipe #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic                          in_valid,
    input  logic [REG_AW-1:0]             in_reg,
    output logic [DEPTH*(REG_AW+1)-1:0]   slots
);

    localparam int SW = REG_AW + 1;

    logic [DEPTH-1:0][SW-1:0] slot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else if (!hold) begin
            slot_q[0] <= {in_valid, in_reg};
            for (int k = 1; k < DEPTH; k++) begin
                slot_q[k] <= slot_q[k-1];
            end
        end
    end

    assign slots = slot_q;

endmodule

// File: rtl/load_hazard_stall_unit.sv
// Load-use hazard detection and stall control between ID and EX.
// Tracks multi-cycle loads past EX, freezes on data-memory busy, and counts stall cycles.
module load_hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_squash,
    input  logic              mem_busy,
    output logic              PC_write,
    output logic              ID_write,
    output logic              ID_flush_lw_stall,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int SW    = REG_AW + 1;
    localparam int NSLOT = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

    logic [NSLOT*SW-1:0] slots;
    logic                rs_hit;
    logic                rt_hit;
    logic                hazard;

    // With single-bubble latency nothing is tracked past EX, so no slots exist.
    generate
        if (LOAD_LAT > 1) begin : g_pend
            load_pending_pipe #(
                .REG_AW (REG_AW),
                .DEPTH  (LOAD_LAT - 1)
            ) u_pend (
                .clk      (clk),
                .rst      (rst),
                .hold     (mem_busy),
                .in_valid (ex_memread && (ex_rt != ZERO_REG)),
                .in_reg   (ex_rt),
                .slots    (slots)
            );
        end else begin : g_nopend
            assign slots = '0;
        end
    endgenerate

    always_comb begin
        rs_hit = ex_memread && (ex_rt == id_rs);
        rt_hit = ex_memread && (ex_rt == id_rt);
        for (int k = 0; k < NSLOT; k++) begin
            if (slots[k*SW + REG_AW] && (slots[k*SW +: REG_AW] == id_rs)) rs_hit = 1'b1;
            if (slots[k*SW + REG_AW] && (slots[k*SW +: REG_AW] == id_rt)) rt_hit = 1'b1;
        end
        hazard = (id_use_rs && rs_hit && (id_rs != ZERO_REG)) ||
                 (id_use_rt && rt_hit && (id_rt != ZERO_REG));
    end

    always_comb begin
        PC_write          = 1'b1;
        ID_write          = 1'b1;
        ID_flush_lw_stall = 1'b0;
        pipe_freeze       = 1'b0;
        if (rst) begin
            PC_write = 1'b1;
        end else if (mem_busy) begin
            PC_write    = 1'b0;
            ID_write    = 1'b0;
            pipe_freeze = 1'b1;
        end else if (id_squash) begin
            PC_write = 1'b1;
        end else if (hazard) begin
            PC_write          = 1'b0;
            ID_write          = 1'b0;
            ID_flush_lw_stall = 1'b1;
        end
    end

    // Saturating: once all-ones the count sticks rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!PC_write && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
